// File: rtl/sm_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sm_run_ctrl
// Brief    : Run/halt/step sequencer for the schoolMIPS core with a PC
//            breakpoint and a halted-only debug register read port.
// Options  : SM_RUN_CTRL_CYCLE_CNT_EN - executed-instruction counter on
//            cycle_cnt (tied to zero when undefined)
// Revision : 1.0 - initial release
// ============================================================================
module sm_run_ctrl #(
    parameter int          STEP_W   = 16,
    parameter logic [31:0] BP_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_arg,
    output logic        cmd_ready,

    input  logic [31:0] cpu_pc,
    output logic        cpu_en,
    output logic        halted,
    output logic [1:0]  halt_cause,

    input  logic        dbg_req,
    input  logic [4:0]  dbg_addr,
    output logic        dbg_ack,
    output logic [31:0] dbg_data,

    output logic [4:0]  regAddr,
    input  logic [31:0] regData,

    output logic [31:0] cycle_cnt
);

    localparam logic [2:0] c_ST_HALT = 3'd0;
    localparam logic [2:0] c_ST_RUN  = 3'd1;
    localparam logic [2:0] c_ST_STEP = 3'd2;
    localparam logic [2:0] c_ST_DRD0 = 3'd3;
    localparam logic [2:0] c_ST_DRD1 = 3'd4;

    localparam logic [1:0] c_OP_HALT  = 2'd0;
    localparam logic [1:0] c_OP_RUN   = 2'd1;
    localparam logic [1:0] c_OP_STEP  = 2'd2;
    localparam logic [1:0] c_OP_SETBP = 2'd3;

    localparam logic [1:0] c_CAUSE_RESET = 2'd0;
    localparam logic [1:0] c_CAUSE_CMD   = 2'd1;
    localparam logic [1:0] c_CAUSE_STEP  = 2'd2;
    localparam logic [1:0] c_CAUSE_BP    = 2'd3;

    localparam logic [STEP_W-1:0] c_CNT_ZERO = '0;
    localparam logic [STEP_W-1:0] c_CNT_ONE  = STEP_W'(1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [1:0]        r_halt_cause;
    logic [1:0]        w_cause_nxt;
    logic [STEP_W-1:0] r_step_cnt;
    logic              r_bp_en;
    logic [31:0]       r_bp_addr;
    logic              r_resume_mask;
    logic              r_dbg_ack;
    logic [31:0]       r_dbg_data;
    logic [4:0]        r_reg_addr;

    logic              w_cmd_fire;
    logic              w_cmd_halt;
    logic              w_cmd_run;
    logic              w_cmd_step;
    logic              w_cmd_setbp;
    logic              w_bp_hit;
    logic              w_step_last;
    logic              w_entry;
    logic [STEP_W-1:0] w_step_arg;

    // ------------------------------------------------------------------
    // Command decode and breakpoint compare
    // ------------------------------------------------------------------
    assign w_cmd_fire  = cmd_valid & cmd_ready;
    assign w_cmd_halt  = w_cmd_fire & (cmd_op == c_OP_HALT);
    assign w_cmd_run   = w_cmd_fire & (cmd_op == c_OP_RUN);
    assign w_cmd_step  = w_cmd_fire & (cmd_op == c_OP_STEP);
    assign w_cmd_setbp = w_cmd_fire & (cmd_op == c_OP_SETBP);

    // The mask lets a resume from a breakpoint PC execute that instruction.
    assign w_bp_hit    = r_bp_en & (cpu_pc == r_bp_addr) & ~r_resume_mask;

    assign w_step_last = (r_step_cnt <= c_CNT_ONE);
    assign w_step_arg  = (cmd_arg[STEP_W-1:0] == c_CNT_ZERO) ? c_CNT_ONE
                                                              : cmd_arg[STEP_W-1:0];
    assign w_entry     = (r_state == c_ST_HALT) & (w_cmd_run | w_cmd_step);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_ST_HALT;
            r_halt_cause <= c_CAUSE_RESET;
        end else begin
            r_state      <= w_state_nxt;
            r_halt_cause <= w_cause_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_halt_cause;
        case (r_state)
            c_ST_HALT: begin
                // A read is not restarted while its ack is still showing.
                if (cmd_valid) begin
                    if (w_cmd_run) begin
                        w_state_nxt = c_ST_RUN;
                    end else if (w_cmd_step) begin
                        w_state_nxt = c_ST_STEP;
                    end
                end else if (dbg_req && !r_dbg_ack) begin
                    w_state_nxt = c_ST_DRD0;
                end
            end
            c_ST_RUN: begin
                if (w_cmd_halt) begin
                    w_state_nxt = c_ST_HALT;
                    w_cause_nxt = c_CAUSE_CMD;
                end else if (w_bp_hit) begin
                    w_state_nxt = c_ST_HALT;
                    w_cause_nxt = c_CAUSE_BP;
                end
            end
            c_ST_STEP: begin
                if (w_cmd_halt) begin
                    w_state_nxt = c_ST_HALT;
                    w_cause_nxt = c_CAUSE_CMD;
                end else if (w_step_last) begin
                    w_state_nxt = c_ST_HALT;
                    w_cause_nxt = c_CAUSE_STEP;
                end
            end
            c_ST_DRD0: begin
                w_state_nxt = c_ST_DRD1;
            end
            c_ST_DRD1: begin
                w_state_nxt = c_ST_HALT;
            end
            default: begin
                w_state_nxt = c_ST_HALT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        cpu_en    = 1'b0;
        halted    = 1'b0;
        case (r_state)
            c_ST_HALT: begin
                cmd_ready = 1'b1;
                halted    = 1'b1;
            end
            c_ST_RUN: begin
                cmd_ready = 1'b1;
                cpu_en    = ~w_bp_hit;
            end
            c_ST_STEP: begin
                cmd_ready = 1'b1;
                cpu_en    = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    assign halt_cause = r_halt_cause;

    // ------------------------------------------------------------------
    // Step counter, breakpoint registers and resume mask
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step_cnt    <= c_CNT_ZERO;
            r_bp_en       <= 1'b0;
            r_bp_addr     <= BP_RESET;
            r_resume_mask <= 1'b0;
        end else begin
            if (r_state == c_ST_STEP) begin
                r_step_cnt <= r_step_cnt - c_CNT_ONE;
            end else if ((r_state == c_ST_HALT) && w_cmd_step) begin
                r_step_cnt <= w_step_arg;
            end

            if (w_cmd_setbp) begin
                r_bp_en   <= cmd_arg[31];
                r_bp_addr <= {1'b0, cmd_arg[30:0]};
            end

            if (w_entry) begin
                r_resume_mask <= 1'b1;
            end else if (cpu_en) begin
                r_resume_mask <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Debug register read path
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_reg_addr <= 5'd0;
            r_dbg_data <= 32'h0;
            r_dbg_ack  <= 1'b0;
        end else begin
            r_dbg_ack <= (r_state == c_ST_DRD1);
            if (r_state == c_ST_DRD0) begin
                r_reg_addr <= dbg_addr;
            end
            if (r_state == c_ST_DRD1) begin
                r_dbg_data <= regData;
            end
        end
    end

    assign regAddr  = r_reg_addr;
    assign dbg_data = r_dbg_data;
    assign dbg_ack  = r_dbg_ack;

    // ------------------------------------------------------------------
    // Executed-instruction counter
    // ------------------------------------------------------------------
`ifdef SM_RUN_CTRL_CYCLE_CNT_EN
    logic [31:0] r_cycle_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle_cnt <= 32'h0;
        end else if (cpu_en) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
`else
    assign cycle_cnt = 32'h0;
`endif

endmodule

`default_nettype wire
